// File: rtl/fw_msg_pkg.sv
// Shared encodings for the firmware message streamer: FSM states, event types,
// ASCII constants and the nibble-to-hex helper.
package fw_msg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_COLON,
    ST_STR,
    ST_SP,
    ST_HEX_A,
    ST_SLASH,
    ST_HEX_B,
    ST_SP2,
    ST_VERDICT,
    ST_EOL
  } state_t;

  localparam int unsigned NUM_TYPES = 4;
  localparam logic [1:0] TYPE_REPORT  = 2'd0;
  localparam logic [1:0] TYPE_WARNING = 2'd1;
  localparam logic [1:0] TYPE_ERROR   = 2'd2;
  localparam logic [1:0] TYPE_COMPARE = 2'd3;

  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_F     = 8'h46;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  function automatic logic [7:0] prefix_ascii(input logic [1:0] typ);
    case (typ)
      TYPE_REPORT:  return ASCII_R;
      TYPE_WARNING: return ASCII_W;
      TYPE_ERROR:   return ASCII_E;
      default:      return ASCII_C;
    endcase
  endfunction

endpackage

// File: rtl/fw_string_mem.sv
// Firmware string buffer: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module fw_string_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fw_msg_streamer.sv
// Queues firmware report/warning/error/compare events and streams each as one ASCII line;
// first char two cycles after the event pulse, holds char_valid/char_data while char_ready is low.
module fw_msg_streamer
  import fw_msg_pkg::*;
#(
  parameter int STR_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             new_report,
  input  logic             new_warning,
  input  logic             new_error,
  input  logic             new_compare,
  input  logic [31:0]      report_reg,
  input  logic [31:0]      warning_reg,
  input  logic [31:0]      error_reg,
  input  logic [31:0]      measured_reg,
  input  logic [31:0]      expected_reg,
  input  logic             write_mem,
  input  logic [7:0]       data,
  input  logic [5:0]       index,
  input  logic             char_ready,
  output logic             char_valid,
  output logic [7:0]       char_data,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] warning_count,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] compare_fail_count
);

  localparam int AW = $clog2(STR_DEPTH);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_pending;
  logic             r_ovf;
  logic [CNT_W-1:0] r_wcnt, r_ecnt, r_fcnt;
  logic [1:0]       r_type;
  logic [AW:0]      r_ptr;
  logic [2:0]       r_nib;
  logic [31:0]      r_rep_val, r_warn_val, r_err_val, r_meas_val, r_exp_val;
  logic [31:0]      r_line_a, r_line_b;

  logic [3:0]  w_pulse, w_accept, w_clr;
  logic [1:0]  w_sel;
  logic        w_dispatch, w_ptr_inc, w_nib_inc, w_vld, w_str_end, w_we;
  logic [7:0]  w_chr, w_rd;
  logic [3:0]  w_nib_a, w_nib_b;

  assign w_we = write_mem && ({26'd0, index} < 32'(STR_DEPTH));

  fw_string_mem #(.DEPTH(STR_DEPTH), .AW(AW)) u_mem (
    .i_clk   (wb_clk_i),
    .i_we    (w_we),
    .i_waddr (index[AW-1:0]),
    .i_wdata (data),
    .i_raddr (r_ptr[AW-1:0]),
    .o_rdata (w_rd)
  );

  // A pulse whose type is still pending is dropped and flagged, never merged.
  assign w_pulse  = {new_compare, new_error, new_warning, new_report};
  assign w_accept = w_pulse & ~r_pending;

  always_comb begin
    w_sel = TYPE_REPORT;
    if (r_pending[0])      w_sel = TYPE_REPORT;
    else if (r_pending[1]) w_sel = TYPE_WARNING;
    else if (r_pending[2]) w_sel = TYPE_ERROR;
    else                   w_sel = TYPE_COMPARE;
  end

  assign w_clr     = w_dispatch ? (4'b0001 << w_sel) : 4'b0000;
  assign w_str_end = r_ptr[AW] || (w_rd == 8'h00);
  assign w_nib_a   = r_line_a[{~r_nib, 2'b00} +: 4];
  assign w_nib_b   = r_line_b[{~r_nib, 2'b00} +: 4];

  always_comb begin
    w_state_nxt = r_state;
    w_vld       = 1'b1;
    w_chr       = ASCII_SPACE;
    w_dispatch  = 1'b0;
    w_ptr_inc   = 1'b0;
    w_nib_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_vld = 1'b0;
        if (|r_pending) begin
          w_dispatch  = 1'b1;
          w_state_nxt = ST_PREFIX;
        end
      end
      ST_PREFIX: begin
        w_chr = prefix_ascii(r_type);
        if (char_ready) w_state_nxt = ST_COLON;
      end
      ST_COLON: begin
        w_chr = ASCII_COLON;
        if (char_ready) w_state_nxt = w_str_end ? ST_SP : ST_STR;
      end
      // The terminator slot carries the space itself so no bubble appears.
      ST_STR: begin
        if (w_str_end) begin
          w_chr = ASCII_SPACE;
          if (char_ready) w_state_nxt = ST_HEX_A;
        end else begin
          w_chr     = w_rd;
          w_ptr_inc = char_ready;
        end
      end
      ST_SP: begin
        w_chr = ASCII_SPACE;
        if (char_ready) w_state_nxt = ST_HEX_A;
      end
      ST_HEX_A: begin
        w_chr     = hex_ascii(w_nib_a);
        w_nib_inc = char_ready;
        if (char_ready && r_nib == 3'd7)
          w_state_nxt = (r_type == TYPE_COMPARE) ? ST_SLASH : ST_EOL;
      end
      ST_SLASH: begin
        w_chr = ASCII_SLASH;
        if (char_ready) w_state_nxt = ST_HEX_B;
      end
      ST_HEX_B: begin
        w_chr     = hex_ascii(w_nib_b);
        w_nib_inc = char_ready;
        if (char_ready && r_nib == 3'd7) w_state_nxt = ST_SP2;
      end
      ST_SP2: begin
        w_chr = ASCII_SPACE;
        if (char_ready) w_state_nxt = ST_VERDICT;
      end
      ST_VERDICT: begin
        w_chr = (r_line_a == r_line_b) ? ASCII_P : ASCII_F;
        if (char_ready) w_state_nxt = ST_EOL;
      end
      ST_EOL: begin
        w_chr = ASCII_LF;
        if (char_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_vld       = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_ovf     <= 1'b0;
      r_wcnt    <= '0;
      r_ecnt    <= '0;
      r_fcnt    <= '0;
      r_type    <= TYPE_REPORT;
      r_ptr     <= '0;
      r_nib     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= (r_pending & ~w_clr) | w_accept;
      if (|(w_pulse & r_pending)) r_ovf <= 1'b1;
      if (w_accept[TYPE_WARNING] && r_wcnt != '1) r_wcnt <= r_wcnt + 1'b1;
      if (w_accept[TYPE_ERROR] && r_ecnt != '1) r_ecnt <= r_ecnt + 1'b1;
      if (w_accept[TYPE_COMPARE] && measured_reg != expected_reg && r_fcnt != '1)
        r_fcnt <= r_fcnt + 1'b1;
      if (w_dispatch) begin
        r_type <= w_sel;
        r_ptr  <= '0;
        r_nib  <= '0;
      end else begin
        if (w_ptr_inc) r_ptr <= r_ptr + 1'b1;
        if (w_nib_inc) r_nib <= r_nib + 1'b1;
      end
    end
  end

  // Line values are copied at dispatch so a re-queued event cannot disturb the line in flight.
  always_ff @(posedge wb_clk_i) begin
    if (w_accept[TYPE_REPORT])  r_rep_val  <= report_reg;
    if (w_accept[TYPE_WARNING]) r_warn_val <= warning_reg;
    if (w_accept[TYPE_ERROR])   r_err_val  <= error_reg;
    if (w_accept[TYPE_COMPARE]) begin
      r_meas_val <= measured_reg;
      r_exp_val  <= expected_reg;
    end
    if (w_dispatch) begin
      case (w_sel)
        TYPE_REPORT:  r_line_a <= r_rep_val;
        TYPE_WARNING: r_line_a <= r_warn_val;
        TYPE_ERROR:   r_line_a <= r_err_val;
        default:      r_line_a <= r_meas_val;
      endcase
      r_line_b <= r_exp_val;
    end
  end

  assign char_valid         = w_vld;
  assign char_data          = w_vld ? w_chr : 8'h00;
  assign busy               = (|r_pending) || (r_state != ST_IDLE);
  assign overflow           = r_ovf;
  assign warning_count      = r_wcnt;
  assign error_count        = r_ecnt;
  assign compare_fail_count = r_fcnt;

endmodule

// File: doc/fw_msg_streamer.md
Name: fw_msg_streamer

Overview:
- Downstream consumer of the firmware-test Wishbone register slave.
- Captures the string bytes and report/warning/error/compare values firmware writes, then queues each event.
- Serialises each event as one ASCII line onto a byte stream with valid/ready handshake, for the testbench console/log sink.
- Keeps saturating warning, error and compare-fail counters for end-of-test pass/fail.

Parameters:
- STR_DEPTH, 64, string buffer depth in bytes; power of two, 2..64.
- CNT_W, 16, width of event counters.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset.
- new_report  in  1  single-cycle event pulse.
- new_warning  in  1  single-cycle event pulse.
- new_error  in  1  single-cycle event pulse.
- new_compare  in  1  single-cycle event pulse.
- report_reg  in  32  report value.
- warning_reg  in  32  warning value.
- error_reg  in  32  error value.
- measured_reg  in  32  compare measured value.
- expected_reg  in  32  compare expected value.
- write_mem  in  1  string byte write strobe.
- data  in  8  string byte.
- index  in  6  string byte address.
- char_ready  in  1  sink accepts char.
- char_valid  out  1  char_data valid.
- char_data  out  8  ASCII character.
- busy  out  1  pending events or streaming.
- overflow  out  1  sticky: event lost.
- warning_count  out  CNT_W  warnings accepted.
- error_count  out  CNT_W  errors accepted.
- compare_fail_count  out  CNT_W  mismatching compares.

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is synchronous, active-high.
- Reset values: all outputs 0; pending mask and FSM cleared. String memory is not reset.
- Reset mid-line: char_valid=0 the cycle after reset; no partial line resumes.
- String memory: STR_DEPTH x 8. Written on write_mem when index<STR_DEPTH; writes with index>=STR_DEPTH are ignored. Writes are accepted in every state. Read is combinational. Coherence during streaming is firmware's responsibility.
- Event capture, cycle N, per asserted pulse:
  - Set its pending bit.
  - Snapshot its value register(s) into private capture regs.
  - Update counters: warning_count+1; error_count+1; compare_fail_count+1 if measured!=expected. All counters saturate at all-ones.
- Repeated event: a pulse whose type is already pending sets overflow and is otherwise ignored; pending bit, snapshot and counters are unchanged.
- Simultaneous pulses: all are accepted in one cycle.
- Dispatch: from IDLE, the lowest-indexed pending type is taken, order report, warning, error, compare. Its pending bit clears on dispatch, so the same type may re-queue while its line streams.
- Latency: pulse in cycle N → char_valid first high in cycle N+2 when idle.
- FSM states: IDLE, PREFIX, COLON, STR, SP, HEX_A, SLASH, HEX_B, SP2, VERDICT, EOL.
  - PREFIX emits 'R'/'W'/'E'/'C'.
  - COLON emits ':'.
  - STR emits bytes from ptr 0. It stops without emitting at a NUL byte or at ptr==STR_DEPTH.
  - SP emits ' '.
  - HEX_A emits 8 uppercase hex digits, MSB nibble first: value for R/W/E, measured for C.
  - R/W/E then go to EOL.
  - C continues: SLASH '/', HEX_B (expected), SP2 ' ', VERDICT 'P' if equal else 'F', then EOL.
  - EOL emits 0x0A, then returns to IDLE.
- Handshake: a char transfers when char_valid&char_ready. char_valid and char_data must hold stable until the transfer. With char_ready held high, one char transfers per cycle with no bubbles between states; STR→SP directly on NUL, no bubble.
- busy = pending!=0 or state!=IDLE.
- overflow clears only on reset.

Decomposition:
- fw_msg_pkg holds:
  - state encoding;
  - type indices REPORT=0, WARNING=1, ERROR=2, COMPARE=3;
  - ASCII constants for prefixes, ':', ' ', '/', 'P', 'F', LF;
  - nibble-to-hex function.
- One sub-module, fw_string_mem: STR_DEPTH x 8, one synchronous write port, one combinational read port.

Test Plan:
1. Bytes 'H','i',0x00 at index 0..2; report_reg=0x0000BEEF; pulse new_report; char_ready=1 → "R:Hi 0000BEEF\n", 14 chars on consecutive cycles from N+2. busy falls after LF.
2. index0=0x00; measured=0x12345678, expected=0x12345679; pulse new_compare → "C: 12345678/12345679 F\n", compare_fail_count=1. Repeat with equal values → line ends " P\n", count stays 1.
3. new_warning and new_error in the same cycle, warning_reg=1, error_reg=2 → "W: 00000001\n" then "E: 00000002\n"; warning_count=1, error_count=1, overflow=0.
4. char_ready toggling every other cycle during test 1 → identical 14-char sequence; char_data stable while valid&!ready; no loss or duplication.
5. Fill all 64 bytes non-zero, pulse new_report; during streaming pulse new_report twice more → first line carries 64 string chars, second report queued, third sets overflow=1; exactly 2 lines emitted.
6. Assert wb_rst_i mid-STR; warning_count=3 before reset → next cycle char_valid=0, busy=0, counts=0, overflow=0; a fresh report afterwards streams correctly.
